// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame transmitter.
package parity_pkg;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam int unsigned FRAME_BITS      = 11;
    localparam int unsigned COUNT_W         = 4;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/byte_parity_count.sv
// Combinational ones counter and even-ones parity for one data byte.
module byte_parity_count
    import parity_pkg::*;
(
    input  logic [FRAME_DATA_BITS-1:0] data,
    output logic [COUNT_W-1:0]         count,
    output logic                       parity
);

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(FRAME_DATA_BITS); i++) begin
            count = count + COUNT_W'(data[i]);
        end
        // 1 when the byte holds an even number of ones
        parity = ~^data;
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial transmitter: start, 8 data bits LSB-first, even-ones parity, stop.
module parity_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_out,
    output logic       busy,
    output logic       parity_out,
    output logic [3:0] ones_count,
    output logic       frame_done
);

    import parity_pkg::*;

    localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_DATA_BITS - 1);

    state_t                       state;
    state_t                       state_nxt;
    logic [DIV_W-1:0]             div_cnt;
    logic [DIV_W-1:0]             div_nxt;
    logic [BIT_W-1:0]             bit_cnt;
    logic [BIT_W-1:0]             bit_nxt;
    logic [FRAME_DATA_BITS-1:0]   shift;
    logic [FRAME_DATA_BITS-1:0]   shift_nxt;
    logic                         parity_nxt;
    logic [COUNT_W-1:0]           count_nxt;
    logic                         tx_nxt;
    logic                         frame_done_nxt;
    logic                         last_tick;
    logic [COUNT_W-1:0]           calc_count;
    logic                         calc_parity;

    byte_parity_count u_count (
        .data   (data_in),
        .count  (calc_count),
        .parity (calc_parity)
    );

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_out <= 1'b0;
            ones_count <= '0;
            tx_out     <= IDLE_LEVEL;
            busy       <= 1'b0;
            ready_out  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            bit_cnt    <= bit_nxt;
            shift      <= shift_nxt;
            parity_out <= parity_nxt;
            ones_count <= count_nxt;
            tx_out     <= tx_nxt;
            busy       <= (state_nxt != IDLE);
            ready_out  <= (state_nxt == IDLE);
            frame_done <= frame_done_nxt;
        end
    end

    // Next-state, divider, bit counter and shifter
    always_comb begin
        state_nxt      = state;
        div_nxt        = div_cnt;
        bit_nxt        = bit_cnt;
        shift_nxt      = shift;
        parity_nxt     = parity_out;
        count_nxt      = ones_count;
        tx_nxt         = IDLE_LEVEL;
        frame_done_nxt = 1'b0;
        last_tick      = (div_cnt == DIV_LAST);

        unique case (state)
            IDLE: begin
                div_nxt = '0;
                bit_nxt = '0;
                if (valid_in) begin
                    shift_nxt  = data_in;
                    parity_nxt = calc_parity;
                    count_nxt  = calc_count;
                    state_nxt  = START;
                end
            end
            START: begin
                if (last_tick) begin
                    div_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                if (last_tick) begin
                    div_nxt   = '0;
                    shift_nxt = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = PARITY;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            PARITY: begin
                if (last_tick) begin
                    div_nxt   = '0;
                    state_nxt = STOP;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            STOP: begin
                if (last_tick) begin
                    div_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                div_nxt   = '0;
                bit_nxt   = '0;
            end
        endcase

        // Outputs are decoded from the upcoming state so they align with it
        unique case (state_nxt)
            IDLE:    tx_nxt = IDLE_LEVEL;
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = parity_nxt;
            STOP:    tx_nxt = 1'b1;
            default: tx_nxt = IDLE_LEVEL;
        endcase

        frame_done_nxt = (state_nxt == STOP) && (div_nxt == DIV_LAST);
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx at CLKS_PER_BIT of 4 and 1.
module tb_parity_frame_tx;

    import parity_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data4, data1;
    logic       valid4, valid1;
    logic       ready4, tx4, busy4, par4, done4;
    logic       ready1, tx1, busy1, par1, done1;
    logic [3:0] cnt4, cnt1;

    int vectors    = 0;
    int miscompares = 0;
    bit sel = 1'b0;

    logic       tx_s, ready_s, busy_s, par_s, done_s;
    logic [3:0] cnt_s;

    always #5 clk = ~clk;

    parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(data4), .valid_in(valid4),
        .ready_out(ready4), .tx_out(tx4), .busy(busy4), .parity_out(par4),
        .ones_count(cnt4), .frame_done(done4)
    );

    parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data1), .valid_in(valid1),
        .ready_out(ready1), .tx_out(tx1), .busy(busy1), .parity_out(par1),
        .ones_count(cnt1), .frame_done(done1)
    );

    assign tx_s    = sel ? tx1    : tx4;
    assign ready_s = sel ? ready1 : ready4;
    assign busy_s  = sel ? busy1  : busy4;
    assign par_s   = sel ? par1   : par4;
    assign done_s  = sel ? done1  : done4;
    assign cnt_s   = sel ? cnt1   : cnt4;

    typedef struct {
        bit         sel;
        logic [7:0] data;
        logic [3:0] cnt;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference serial line: bit index 0..10 of the frame for byte b
    function automatic logic exp_line(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9) return ($countones(b) % 2 == 0);
        return 1'b1;
    endfunction

    task automatic drive(input logic v, input logic [7:0] d);
        if (sel) begin
            valid1 = v;
            data1  = d;
        end else begin
            valid4 = v;
            data4  = d;
        end
    endtask

    // Called at a negedge with the selected DUT idle; ends on the idle cycle after the frame
    task automatic send(input bit s, input logic [7:0] b, input bit hold,
                        input logic [7:0] mid, input logic [3:0] ecnt, input logic epar);
        int cpb;
        int n;
        sel = s;
        cpb = s ? 1 : 4;
        n   = int'(FRAME_BITS) * cpb;
        check("ready_before", ready_s, 1);
        drive(1'b1, b);
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check("tx_line", tx_s, exp_line(b, (k - 1) / cpb));
            check("frame_done", done_s, (k == n));
            check("busy_mid", busy_s, 1);
            check("ready_mid", ready_s, 0);
            if (k == 1) begin
                check("ones_count", cnt_s, ecnt);
                check("parity_out", par_s, epar);
                drive(hold, mid);
            end
        end
        @(negedge clk);
        check("ready_idle", ready_s, 1);
        check("tx_idle", tx_s, 1);
        check("done_idle", done_s, 0);
        check("busy_idle", busy_s, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [3:0] c;

        vecs[0] = '{1'b0, 8'hFF, 4'd8, 1'b1};
        vecs[1] = '{1'b0, 8'hAD, 4'd5, 1'b0};
        vecs[2] = '{1'b1, 8'h00, 4'd0, 1'b1};
        vecs[3] = '{1'b0, 8'h80, 4'd1, 1'b0};
        vecs[4] = '{1'b0, 8'h7F, 4'd7, 1'b0};
        vecs[5] = '{1'b1, 8'hFF, 4'd8, 1'b1};
        vecs[6] = '{1'b1, 8'hAD, 4'd5, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 4'd0, 1'b1};

        rst_n  = 1'b0;
        valid4 = 1'b1;
        data4  = 8'hFF;
        valid1 = 1'b1;
        data1  = 8'hFF;

        // Reset holds everything idle even with valid asserted
        repeat (3) @(negedge clk);
        check("rst_tx4", tx4, 1);
        check("rst_ready4", ready4, 1);
        check("rst_busy4", busy4, 0);
        check("rst_cnt4", cnt4, 0);
        check("rst_par4", par4, 0);
        check("rst_done4", done4, 0);
        check("rst_tx1", tx1, 1);
        check("rst_ready1", ready1, 1);
        check("rst_cnt1", cnt1, 0);

        rst_n  = 1'b1;
        valid1 = 1'b0;
        send(1'b0, 8'hFF, 1'b0, 8'h3C, 4'd8, 1'b1);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].sel, vecs[i].data, 1'b0, 8'(i * 37 + 5), vecs[i].cnt, vecs[i].par);
        end

        // Back-to-back with valid held and data changed mid-frame
        send(1'b0, 8'h0F, 1'b1, 8'h01, 4'd4, 1'b1);
        send(1'b0, 8'h01, 1'b0, 8'h55, 4'd1, 1'b0);
        send(1'b1, 8'h0F, 1'b1, 8'h01, 4'd4, 1'b1);
        send(1'b1, 8'h01, 1'b0, 8'h55, 4'd1, 1'b0);

        // Reset in the middle of the DATA phase
        sel = 1'b0;
        drive(1'b1, 8'hC3);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 8'h00);
        repeat (13) @(negedge clk);
        check("mid_data_tx", tx4, 0);
        check("mid_data_busy", busy4, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx4, 1);
        check("async_rst_busy", busy4, 0);
        check("async_rst_ready", ready4, 1);
        check("async_rst_done", done4, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_done", done4, 0);
            check("rst_hold_tx", tx4, 1);
        end
        rst_n = 1'b1;
        send(1'b0, 8'hAD, 1'b0, 8'h00, 4'd5, 1'b0);

        // Randomized frames against the reference model
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            c = 4'($countones(b));
            send(1'($urandom_range(0, 1)), b, 1'b0, 8'($urandom), c, ~c[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
